ff_excitation_driver: RTL and testbench

Inverse companion to the team's D/T/JK flip-flop primitives: rather than applying inputs and observing the next state, this block accepts a requested next-state vector and derives the minimal J/K or T excitation that produces it. It drives an internal WIDTH-bit bank of JK/T cells with that excitation, checks that the bank reached the target, and reports the excitation, the resulting Q and a pass/fail flag. The block serves as a reusable register front-end and as a self-check harness for the flip-flop primitives.

---
 rtl/ff_exc_pkg.sv | 35 +++
 rtl/jkt_cell.sv | 33 +++
 rtl/ff_excitation_driver.sv | 140 ++++++++++++++
 tb/tb_ff_excitation_driver.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/ff_exc_pkg.sv
// Shared types and excitation helpers for ff_excitation_driver and its JK/T bank cells.
package ff_exc_pkg;

   localparam int unsigned MAX_W = 32;

   localparam logic MODE_JK = 1'b0;
   localparam logic MODE_T  = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      EXCITE,
      REPORT
   } state_e;

   typedef struct packed {
      logic [MAX_W-1:0] a;
      logic [MAX_W-1:0] b;
   } exc_t;

   // Minimal JK excitation: set bits that must rise, reset bits that must fall.
   function automatic exc_t jk_exc(input logic [MAX_W-1:0] t, input logic [MAX_W-1:0] q);
      exc_t e;
      e.a = t & ~q;
      e.b = ~t & q;
      return e;
   endfunction

   function automatic exc_t t_exc(input logic [MAX_W-1:0] t, input logic [MAX_W-1:0] q);
      exc_t e;
      e.a = t ^ q;
      e.b = '0;
      return e;
   endfunction

endpackage

// File: rtl/jkt_cell.sv
// Single-bit JK/T storage cell; holds its value whenever the active excitation is zero.
module jkt_cell
   import ff_exc_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic j,
   input  logic k,
   input  logic t,
   input  logic mode,
   output logic q
);

   logic r_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_q <= 1'b0;
      end else if (mode == MODE_T) begin
         r_q <= r_q ^ t;
      end else begin
         case ({j, k})
            2'b01:   r_q <= 1'b0;
            2'b10:   r_q <= 1'b1;
            2'b11:   r_q <= ~r_q;
            default: r_q <= r_q;
         endcase
      end
   end

   assign q = r_q;

endmodule

// File: rtl/ff_excitation_driver.sv
// Derives J/K or T excitation for a requested next state, applies it to a JK/T bank and reports.
// Optional comparator and sticky error flag are built when FF_EXC_CHECK_EN is defined.
module ff_excitation_driver
   import ff_exc_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_target,
   input  logic             in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_exc_a,
   output logic [WIDTH-1:0] out_exc_b,
   output logic [WIDTH-1:0] out_q,
   output logic             out_err,
   output logic             err_sticky,
   output logic [CNT_W-1:0] xfer_count
);

   state_e           r_state, w_state_nxt;
   logic             r_ready_en;
   logic [WIDTH-1:0] r_target;
   logic             r_mode;
   logic [WIDTH-1:0] r_exc_a, r_exc_b;
   logic [CNT_W-1:0] r_count;
   logic             w_accept, w_excite, w_done;
   logic [WIDTH-1:0] w_q, w_j, w_k, w_t;
   exc_t             w_exc;
   logic             w_unused_exc;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (w_accept) w_state_nxt = EXCITE;
         EXCITE:  w_state_nxt = REPORT;
         REPORT:  if (out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == IDLE) && r_ready_en;
      out_valid = (r_state == REPORT);
      w_excite  = (r_state == EXCITE);
      w_accept  = in_valid && in_ready;
      w_done    = out_valid && out_ready;
   end

   // Keeps in_ready low through reset and releases it on the first clock afterwards.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_ready_en <= 1'b0;
      else          r_ready_en <= 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_target <= '0;
         r_mode   <= MODE_JK;
         r_exc_a  <= '0;
         r_exc_b  <= '0;
         r_count  <= '0;
      end else begin
         if (w_accept) begin
            r_target <= in_target;
            r_mode   <= in_mode;
         end
         if (w_excite) begin
            r_exc_a <= w_exc.a[WIDTH-1:0];
            r_exc_b <= w_exc.b[WIDTH-1:0];
         end
         if (w_done) r_count <= r_count + 1'b1;
      end
   end

   always_comb begin
      if (r_mode == MODE_T) w_exc = t_exc(MAX_W'(r_target), MAX_W'(w_q));
      else                  w_exc = jk_exc(MAX_W'(r_target), MAX_W'(w_q));
   end

   assign w_unused_exc = ^w_exc;

   // Excitation reaches the bank only during EXCITE, so the bank holds otherwise.
   always_comb begin
      w_j = '0;
      w_k = '0;
      w_t = '0;
      if (w_excite) begin
         if (r_mode == MODE_T) begin
            w_t = w_exc.a[WIDTH-1:0];
         end else begin
            w_j = w_exc.a[WIDTH-1:0];
            w_k = w_exc.b[WIDTH-1:0];
         end
      end
   end

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bank
      jkt_cell u_cell (
         .clk     (clk),
         .reset_n (reset_n),
         .j       (w_j[gi]),
         .k       (w_k[gi]),
         .t       (w_t[gi]),
         .mode    (r_mode),
         .q       (w_q[gi])
      );
   end

`ifdef FF_EXC_CHECK_EN
   logic r_err_sticky;

   assign out_err = out_valid && (w_q != r_target);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     r_err_sticky <= 1'b0;
      else if (out_err) r_err_sticky <= 1'b1;
   end

   assign err_sticky = r_err_sticky;
`else
   assign out_err    = 1'b0;
   assign err_sticky = 1'b0;
`endif

   assign out_exc_a  = r_exc_a;
   assign out_exc_b  = r_exc_b;
   assign out_q      = w_q;
   assign xfer_count = r_count;

endmodule

// File: tb/tb_ff_excitation_driver.sv
// Directed self-checking bench for ff_excitation_driver (fault-injection steps need FF_EXC_CHECK_EN).
module tb_ff_excitation_driver;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned CNT_W = 16;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_target;
   logic             in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_exc_a;
   logic [WIDTH-1:0] out_exc_b;
   logic [WIDTH-1:0] out_q;
   logic             out_err;
   logic             err_sticky;
   logic [CNT_W-1:0] xfer_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ff_excitation_driver #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_target  (in_target),
      .in_mode    (in_mode),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_exc_a  (out_exc_a),
      .out_exc_b  (out_exc_b),
      .out_q      (out_q),
      .out_err    (out_err),
      .err_sticky (err_sticky),
      .xfer_count (xfer_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One transaction: request on a negedge, EXCITE next cycle, REPORT the one after.
   task automatic txn(input string tag, input logic [7:0] tgt, input logic md,
                      input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] eq,
                      input logic eerr, input logic esticky, input int hold);
      logic [15:0] cnt0;
      @(negedge clk);
      chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      cnt0      = xfer_count;
      in_valid  = 1'b1;
      in_target = tgt;
      in_mode   = md;
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = (hold == 0);
      chk({tag, ".excite_valid"}, 32'(out_valid), 32'd0);
      chk({tag, ".excite_ready"}, 32'(in_ready), 32'd0);
      @(negedge clk);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".exc_a"}, 32'(out_exc_a), 32'(ea));
      chk({tag, ".exc_b"}, 32'(out_exc_b), 32'(eb));
      chk({tag, ".q"}, 32'(out_q), 32'(eq));
      chk({tag, ".err"}, 32'(out_err), 32'(eerr));
      for (int i = 0; i < hold; i++) begin
         in_valid  = (i == 0);
         in_target = 8'h5A;
         @(negedge clk);
         in_valid = 1'b0;
         chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
         chk({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
         chk({tag, ".hold_q"}, 32'(out_q), 32'(eq));
         chk({tag, ".hold_exc_a"}, 32'(out_exc_a), 32'(ea));
         chk({tag, ".hold_exc_b"}, 32'(out_exc_b), 32'(eb));
         chk({tag, ".hold_count"}, 32'(xfer_count), 32'(cnt0));
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk({tag, ".done_valid"}, 32'(out_valid), 32'd0);
      chk({tag, ".done_ready"}, 32'(in_ready), 32'd1);
      chk({tag, ".done_q"}, 32'(out_q), 32'(eq));
      chk({tag, ".count"}, 32'(xfer_count), 32'(cnt0 + 16'd1));
      chk({tag, ".sticky"}, 32'(err_sticky), 32'(esticky));
   endtask

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_target = '0;
      in_mode   = 1'b0;
      out_ready = 1'b1;
      #3;
      chk("rst.in_ready", 32'(in_ready), 32'd0);
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.q", 32'(out_q), 32'd0);
      chk("rst.exc_a", 32'(out_exc_a), 32'd0);
      chk("rst.count", 32'(xfer_count), 32'd0);
      chk("rst.sticky", 32'(err_sticky), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("rel.in_ready_low", 32'(in_ready), 32'd0);

      txn("jk_a5", 8'hA5, 1'b0, 8'hA5, 8'h00, 8'hA5, 1'b0, 1'b0, 0);
      txn("jk_3c", 8'h3C, 1'b0, 8'h18, 8'h81, 8'h3C, 1'b0, 1'b0, 0);
      txn("t_ff",  8'hFF, 1'b1, 8'hC3, 8'h00, 8'hFF, 1'b0, 1'b0, 0);
      txn("t_eq",  8'hFF, 1'b1, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 0);
      txn("hold",  8'h0F, 1'b0, 8'h00, 8'hF0, 8'h0F, 1'b0, 1'b0, 5);
      chk("count5", 32'(xfer_count), 32'd5);

      // Reset during EXCITE aborts the transaction and clears the bank.
      @(negedge clk);
      in_valid  = 1'b1;
      in_target = 8'hF0;
      in_mode   = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      reset_n  = 1'b0;
      #1;
      chk("abort.in_ready", 32'(in_ready), 32'd0);
      chk("abort.out_valid", 32'(out_valid), 32'd0);
      chk("abort.q", 32'(out_q), 32'd0);
      chk("abort.exc_a", 32'(out_exc_a), 32'd0);
      chk("abort.exc_b", 32'(out_exc_b), 32'd0);
      chk("abort.count", 32'(xfer_count), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      txn("post_rst", 8'h01, 1'b0, 8'h01, 8'h00, 8'h01, 1'b0, 1'b0, 0);
      chk("count_post", 32'(xfer_count), 32'd1);

`ifdef FF_EXC_CHECK_EN
      txn("clr0", 8'h00, 1'b0, 8'h00, 8'h01, 8'h00, 1'b0, 1'b0, 0);
      force dut.g_bank[0].u_cell.r_q = 1'b0;
      txn("stuck", 8'h01, 1'b0, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 0);
      release dut.g_bank[0].u_cell.r_q;
      txn("after", 8'h02, 1'b0, 8'h02, 8'h00, 8'h02, 1'b0, 1'b1, 0);
`else
      txn("mode_mix", 8'h80, 1'b1, 8'h81, 8'h00, 8'h80, 1'b0, 1'b0, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
